// File: rtl/pipe_io_port_if.sv
// Data-bus interface between the MEM stage and the I/O responder.
// The master side is the pipeline and the slave side is pipe_io_port.
interface pipe_io_port_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] rdata;
    logic        io_sel;

    modport master (
        output addr,
        output wdata,
        output we,
        input  rdata,
        input  io_sel
    );

    modport slave (
        input  addr,
        input  wdata,
        input  we,
        output rdata,
        output io_sel
    );
endinterface : pipe_io_port_if

// File: rtl/pipe_io_port.sv
// pipe_io_port: memory-mapped I/O responder on the MEM-stage data bus.
// It provides the following functions:
//   - switch and key synchronisers, with sticky key-press flags
//   - the LED register
//   - six active-low 7-segment digits
//   - a free-running cycle timer
// Optional build macro HEX_BLANK_EN adds a per-digit blanking register at
// word offset 0x1C. Without it, that offset reads 0 and digits are never blanked.
module pipe_io_port #(
    parameter logic [31:0] IO_BASE = 32'h0000_0080,
    parameter int          TIMER_W = 32
) (
    input  logic               clock,
    input  logic               reset,
    pipe_io_port_if.slave      bus,
    input  logic [9:0]         sw,
    input  logic [2:0]         key,
    output logic [9:0]         led,
    output logic [6:0]         hex5,
    output logic [6:0]         hex4,
    output logic [6:0]         hex3,
    output logic [6:0]         hex2,
    output logic [6:0]         hex1,
    output logic [6:0]         hex0
);

    // Word offsets inside the 32-byte window (addr[4:2]).
    localparam logic [2:0] OFF_SW      = 3'd0;
    localparam logic [2:0] OFF_KEY     = 3'd1;
    localparam logic [2:0] OFF_KEYEDGE = 3'd2;
    localparam logic [2:0] OFF_LED     = 3'd3;
    localparam logic [2:0] OFF_HEXLO   = 3'd4;
    localparam logic [2:0] OFF_HEXHI   = 3'd5;
    localparam logic [2:0] OFF_TIMER   = 3'd6;
    localparam logic [2:0] OFF_BLANK   = 3'd7;

    // Standard active-low glyphs, bit order gfedcba.
    function automatic logic [6:0] seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Synchroniser stages. The third key stage exists only for edge detection.
    logic [9:0]         sw_s1_q, sw_s1_d;
    logic [9:0]         sw_s2_q, sw_s2_d;
    logic [2:0]         key_s1_q, key_s1_d;
    logic [2:0]         key_s2_q, key_s2_d;
    logic [2:0]         key_s3_q, key_s3_d;

    // Architectural registers.
    logic [2:0]         keyedge_q, keyedge_d;
    logic [9:0]         led_q, led_d;
    logic [15:0]        hexlo_q, hexlo_d;
    logic [7:0]         hexhi_q, hexhi_d;
    logic [TIMER_W-1:0] timer_q, timer_d;

    logic [2:0]         reg_idx;
    logic               wr_hit;
    logic [2:0]         key_press;
    logic [31:0]        timer_rd;
    logic [5:0]         blank_mask;

    // addr[1:0] is ignored. wdata upper bits go unused when TIMER_W < 32.
    logic               unused_bus_bits;
    assign unused_bus_bits = ^{bus.addr[1:0], bus.wdata};

    // Window decode and the store strobe qualified by it.
    assign bus.io_sel = (bus.addr[31:5] == IO_BASE[31:5]);
    assign reg_idx    = bus.addr[4:2];
    assign wr_hit     = bus.we & bus.io_sel;

    // A press is a released->pressed (1->0) transition between stages 3 and 2.
    assign key_press  = key_s3_q & ~key_s2_q;

`ifdef HEX_BLANK_EN
    logic [5:0] blank_q, blank_d;

    // Next-state for the blanking register.
    always_comb begin
        blank_d = blank_q;
        if (wr_hit && reg_idx == OFF_BLANK) begin
            blank_d = bus.wdata[5:0];
        end
    end

    // Blanking register. A reset overrides a store in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            blank_q <= '0;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign blank_mask = blank_q;
`else
    assign blank_mask = '0;
`endif

    // Next-state for synchronisers, W1C flags, RW registers and the timer.
    always_comb begin
        sw_s1_d   = sw;
        sw_s2_d   = sw_s1_q;
        key_s1_d  = key;
        key_s2_d  = key_s1_q;
        key_s3_d  = key_s2_q;
        keyedge_d = keyedge_q;
        led_d     = led_q;
        hexlo_d   = hexlo_q;
        hexhi_d   = hexhi_q;
        timer_d   = timer_q + TIMER_W'(1);

        if (wr_hit) begin
            case (reg_idx)
                OFF_KEYEDGE: keyedge_d = keyedge_q & ~bus.wdata[2:0];
                OFF_LED:     led_d     = bus.wdata[9:0];
                OFF_HEXLO:   hexlo_d   = bus.wdata[15:0];
                OFF_HEXHI:   hexhi_d   = bus.wdata[7:0];
                OFF_TIMER:   timer_d   = bus.wdata[TIMER_W-1:0];
                default:     ;
            endcase
        end

        // OR in the set after the clear, so a new press beats a same-cycle W1C.
        keyedge_d = keyedge_d | key_press;
    end

    // State registers. A reset overrides a store in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            sw_s1_q   <= '0;
            sw_s2_q   <= '0;
            key_s1_q  <= 3'b111;
            key_s2_q  <= 3'b111;
            key_s3_q  <= 3'b111;
            keyedge_q <= '0;
            led_q     <= '0;
            hexlo_q   <= '0;
            hexhi_q   <= '0;
            timer_q   <= '0;
        end else begin
            sw_s1_q   <= sw_s1_d;
            sw_s2_q   <= sw_s2_d;
            key_s1_q  <= key_s1_d;
            key_s2_q  <= key_s2_d;
            key_s3_q  <= key_s3_d;
            keyedge_q <= keyedge_d;
            led_q     <= led_d;
            hexlo_q   <= hexlo_d;
            hexhi_q   <= hexhi_d;
            timer_q   <= timer_d;
        end
    end

    // Zero-extend the timer to the bus width.
    always_comb begin
        timer_rd                = '0;
        timer_rd[TIMER_W-1:0]   = timer_q;
    end

    // Load data mux. It is combinational and has no side effects. Reads outside the window return 0.
    always_comb begin
        bus.rdata = '0;
        if (bus.io_sel) begin
            case (reg_idx)
                OFF_SW:      bus.rdata = {22'd0, sw_s2_q};
                OFF_KEY:     bus.rdata = {29'd0, key_s2_q};
                OFF_KEYEDGE: bus.rdata = {29'd0, keyedge_q};
                OFF_LED:     bus.rdata = {22'd0, led_q};
                OFF_HEXLO:   bus.rdata = {16'd0, hexlo_q};
                OFF_HEXHI:   bus.rdata = {24'd0, hexhi_q};
                OFF_TIMER:   bus.rdata = timer_rd;
`ifdef HEX_BLANK_EN
                OFF_BLANK:   bus.rdata = {26'd0, blank_q};
`endif
                default:     bus.rdata = '0;
            endcase
        end
    end

    // Board outputs: the LED register and the decoded digits with optional blanking.
    always_comb begin
        led  = led_q;
        hex0 = blank_mask[0] ? 7'b1111111 : seg7(hexlo_q[3:0]);
        hex1 = blank_mask[1] ? 7'b1111111 : seg7(hexlo_q[7:4]);
        hex2 = blank_mask[2] ? 7'b1111111 : seg7(hexlo_q[11:8]);
        hex3 = blank_mask[3] ? 7'b1111111 : seg7(hexlo_q[15:12]);
        hex4 = blank_mask[4] ? 7'b1111111 : seg7(hexhi_q[3:0]);
        hex5 = blank_mask[5] ? 7'b1111111 : seg7(hexhi_q[7:4]);
    end

endmodule : pipe_io_port

// File: doc/pipe_io_port.md
Name: pipe_io_port

Overview:
Memory-mapped I/O responder at the far end of the MEM-stage data bus. It answers loads and stores that the pipeline issues into the I/O window, and turns them into board-level state:
- switch and key sampling, including sticky key-press flags
- LED register
- six 7-segment digits
- a free-running cycle timer

It sits beside the data RAM. The MEM stage muxes this block's rdata into the load result whenever io_sel is high.

Parameters:
IO_BASE, 32'h0000_0080, word-aligned base of the 32-byte I/O window; bits [4:0] must be 0.
TIMER_W, 32, timer counter width; 1..32; zero-extended on read.

Ports:
clock  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
addr  input  32  bus byte address; bits [1:0] ignored.
wdata  input  32  store data.
we  input  1  store strobe, valid for one cycle per store.
rdata  output  32  load data, combinational from addr and current register state.
io_sel  output  1  high when addr[31:5] == IO_BASE[31:5]; combinational.
sw  input  10  raw board switches, asynchronous.
key  input  3  raw keys [3:1], active-low, asynchronous.
led  output  10  LED register.
hex5, hex4, hex3, hex2, hex1, hex0  output  7 each  active-low segments, bit order gfedcba.

Behaviour:
- One clock domain; reset is synchronous and active-high.
- Register map, word offset from IO_BASE:
  - 0x00 SW (RO): 2-flop-synchronised sw in [9:0], upper bits 0.
  - 0x04 KEY (RO): synchronised key level in [2:0] (key1 in bit 0); 1 = released.
  - 0x08 KEYEDGE (R/W1C): sticky press flags in [2:0].
  - 0x0C LED (RW): [9:0] drives led.
  - 0x10 HEXLO (RW): [15:0] = nibbles for hex3..hex0, hex0 in [3:0].
  - 0x14 HEXHI (RW): [7:0] = nibbles for hex5, hex4.
  - 0x18 TIMER (RW): counter value.
  - 0x1C: see Optional Feature.
- RW registers read back only their implemented bits; all other bits read 0.
- Addresses outside the window: rdata = 0, io_sel = 0, stores ignored.
- Loads have no side effects. Store latency is 1 cycle: the new value is visible on outputs and rdata the cycle after we.
- Synchronisers:
  - sw_s1, sw_s2 reset to 0.
  - key_s1, key_s2 reset to 3'b111; a third stage key_s3 also resets to 3'b111.
  - Press event = key_s3 & ~key_s2 (a 1->0 transition), so a press reaches KEYEDGE 3 cycles after the pin falls.
- KEYEDGE:
  - Flag set on a press event.
  - Cleared by a store to 0x08 with 1 in the corresponding wdata bit.
  - If a press event and a W1C hit the same bit in the same cycle, set wins.
  - Releasing the key does not clear the flag.
- TIMER:
  - Increments by 1 every cycle, wrapping from 2^TIMER_W-1 to 0.
  - A store loads wdata[TIMER_W-1:0] with no increment that cycle, so the next read returns wdata.
- Hex decode is combinational from the nibble registers: 0-F map to standard active-low glyphs (0 = 7'b1000000, 8 = 7'b0000000, F = 7'b0001110).
- Reset values:
  - led = 0, HEXLO = HEXHI = 0, so every digit shows "0" (7'b1000000).
  - KEYEDGE = 0, TIMER = 0, synchronisers as listed above.
- Reset asserted mid-operation overrides any same-cycle store.

Optional Feature:
HEX_BLANK_EN
- Defined: offset 0x1C is a RW register BLANK[5:0], reset value 0. A 1 in bit n forces hexn to 7'b1111111 (digit off).
- Undefined: offset 0x1C reads 0, stores to it are ignored, and no digit is ever blanked.

Test Plan:
1. Reset, then read 0x80..0x98 -> 0, 0x7, 0, 0, 0, 0, small count. hex0..hex5 = 7'b1000000, led = 0.
2. Store 0x3FF to 0x8C, then store 0xFFFFFFFF to 0x8C -> led = 10'h3FF both times; read of 0x8C returns 0x3FF. Store to 0x100 -> led unchanged, io_sel = 0, rdata = 0.
3. Store 0x0000_F8A3 to 0x90 -> hex0 = 7'b0110000 (3), hex1 = 7'b0001000 (A), hex2 = 7'b0000000 (8), hex3 = 7'b0001110 (F).
4. Drive key[2] low at cycle t -> KEY bit 1 reads 0 from t+2; KEYEDGE reads 0x2 from t+3. Release key -> still 0x2. Store 0x2 to 0x88 -> reads 0. Repeat with the press landing in the same cycle as the W1C store -> flag stays 1.
5. Store 0xFFFFFFFE to 0x98 -> next cycle reads 0xFFFFFFFE, then 0xFFFFFFFF, then 0x0 (wrap). Toggle sw to 0x155 -> 0x80 reads 0x155 two cycles later.
6. With HEX_BLANK_EN: store 0x21 to 0x9C -> hex0 and hex5 = 7'b1111111, others unchanged; reset -> all digits visible. Without the macro: read of 0x9C = 0 and no digit blanks.
